// File: rtl/arbitor_pkg.sv
// Shared types and constants for the arbitor request arbiter.
// Latency/backpressure: n/a (types only).
package arbitor_pkg;

  typedef enum logic {ST_IDLE, ST_GRANT} arb_state_t;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Bit positions inside reg0 of the AXI4-Lite configuration block
  localparam int CFG_EN_BIT   = 0;
  localparam int CFG_MODE_BIT = 1;
  localparam int CFG_CLR_BIT  = 2;

endpackage

// File: rtl/arbitor_rr_pick.sv
// Combinational picker: rotating priority after last_idx (RR) or lowest index (fixed).
// Latency: 0 cycles; backpressure: none.
module arbitor_rr_pick
  import arbitor_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   last_idx,
  input  logic               mode,
  output logic               found,
  output logic [IDX_W-1:0]   winner
);

  localparam logic [IDX_W:0] ONE    = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] NREQ_V = (IDX_W+1)'(NUM_REQ);

  // One extra bit so base+k can exceed NUM_REQ-1 before a single wrap
  logic [IDX_W:0] base;
  logic [IDX_W:0] idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    base   = (mode == MODE_FIXED) ? '0 : ({1'b0, last_idx} + ONE);
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = base + k[IDX_W:0];
      if (idx >= NREQ_V) idx = idx - NREQ_V;
      if (!found && eligible[idx[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/arbitor_core.sv
// Round-robin / fixed-priority arbiter with hold-time preemption and grant counters.
// Latency: req sampled at n gives gnt at n+1; no backpressure, one idle bubble between grants.
module arbitor_core
  import arbitor_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int HOLD_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     cfg_enable,
  input  logic                     cfg_mode,
  input  logic [HOLD_W-1:0]        cfg_max_hold,
  input  logic                     cfg_cnt_clr,
  input  logic [NUM_REQ-1:0]       req,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     gnt_valid,
  output logic                     timeout_sticky,
  output logic [NUM_REQ*CNT_W-1:0] gnt_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t           state;
  logic [IDX_W-1:0]     last_idx;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [NUM_REQ-1:0]   pre_mask;
  logic [CNT_W-1:0]     cnt_q [NUM_REQ];

  logic [NUM_REQ-1:0]   eligible;
  logic                 found;
  logic [IDX_W-1:0]     win_idx;
  logic                 grant_start;
  logic                 cur_req;
  logic                 limit_hit;
  logic                 preempt;
  logic                 rel_now;
  logic [NUM_REQ-1:0]   set_mask;

  assign eligible = req & ~pre_mask;

  arbitor_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .eligible (eligible),
    .last_idx (last_idx),
    .mode     (cfg_mode),
    .found    (found),
    .winner   (win_idx)
  );

  // While granted, last_idx names the current owner
  always_comb begin
    grant_start = (state == ST_IDLE) && cfg_enable && found;
    cur_req     = req[last_idx];
    limit_hit   = (cfg_max_hold != '0) && (hold_cnt == cfg_max_hold);
    preempt     = (state == ST_GRANT) && cur_req && limit_hit;
    rel_now     = (state == ST_GRANT) && (!cur_req || limit_hit);
    set_mask    = preempt ? (NUM_REQ'(1) << last_idx) : '0;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state          <= ST_IDLE;
      gnt            <= '0;
      last_idx       <= IDX_W'(NUM_REQ - 1);
      hold_cnt       <= '0;
      pre_mask       <= '0;
      timeout_sticky <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      pre_mask       <= (pre_mask & req) | set_mask;
      timeout_sticky <= preempt | (timeout_sticky & ~cfg_cnt_clr);

      for (int i = 0; i < NUM_REQ; i++) begin
        if (cfg_cnt_clr) begin
          cnt_q[i] <= '0;
        end else if (grant_start && (win_idx == IDX_W'(i)) && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end

      case (state)
        ST_IDLE: begin
          if (grant_start) begin
            state    <= ST_GRANT;
            gnt      <= NUM_REQ'(1) << win_idx;
            last_idx <= win_idx;
            hold_cnt <= HOLD_W'(1);
          end
        end
        ST_GRANT: begin
          // Saturate so an unlimited grant never wraps into a false limit match
          if (hold_cnt != '1) hold_cnt <= hold_cnt + HOLD_W'(1);
          if (rel_now) begin
            gnt   <= '0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

  assign gnt_valid = |gnt;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign gnt_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_arbitor_core.sv
// Bench for arbitor_core: directed scenarios plus random traffic against a cycle-level model
// built from the arbitration rules (current owner, cycles held, masked requesters, counts).
module tb_arbitor_core;

  localparam int NREQ  = 4;
  localparam int HW    = 8;
  localparam int CW    = 4;
  localparam int CMAX  = 15;
  localparam int HMAX  = 255;

  logic                 ACLK;
  logic                 ARESET;
  logic                 cfg_enable;
  logic                 cfg_mode;
  logic [HW-1:0]        cfg_max_hold;
  logic                 cfg_cnt_clr;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      gnt;
  logic                 gnt_valid;
  logic                 timeout_sticky;
  logic [NREQ*CW-1:0]   gnt_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_cur;
  int m_held;
  int m_last;
  bit m_mask [NREQ];
  bit m_sticky;
  int m_cnt  [NREQ];

  arbitor_core #(.NUM_REQ(NREQ), .HOLD_W(HW), .CNT_W(CW)) dut (
    .ACLK           (ACLK),
    .ARESET         (ARESET),
    .cfg_enable     (cfg_enable),
    .cfg_mode       (cfg_mode),
    .cfg_max_hold   (cfg_max_hold),
    .cfg_cnt_clr    (cfg_cnt_clr),
    .req            (req),
    .gnt            (gnt),
    .gnt_valid      (gnt_valid),
    .timeout_sticky (timeout_sticky),
    .gnt_cnt        (gnt_cnt)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  function automatic logic [NREQ-1:0] exp_gnt();
    return (m_cur < 0) ? '0 : NREQ'(1 << m_cur);
  endfunction

  function automatic logic [CW-1:0] cnt_of(int i);
    return gnt_cnt[i*CW +: CW];
  endfunction

  // Advance one clock: model consumes the inputs present at the edge, DUT sampled 1 time unit later
  task automatic tick();
    int w;
    int idx;
    int pre_idx;
    bit pre;
    @(posedge ACLK);
    w = -1; pre = 1'b0; pre_idx = 0;
    if (ARESET) begin
      m_cur = -1; m_held = 0; m_last = NREQ - 1; m_sticky = 1'b0;
      for (int i = 0; i < NREQ; i++) begin m_mask[i] = 1'b0; m_cnt[i] = 0; end
    end else begin
      if (m_cur >= 0) begin
        if (!req[m_cur]) m_cur = -1;
        else if (cfg_max_hold != 0 && m_held == int'(cfg_max_hold)) begin
          pre = 1'b1; pre_idx = m_cur; m_cur = -1;
        end else if (m_held < HMAX) m_held++;
      end else if (cfg_enable) begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = cfg_mode ? k - 1 : (m_last + k) % NREQ;
          if (w < 0 && req[idx] && !m_mask[idx]) w = idx;
        end
        if (w >= 0) begin
          m_cur = w; m_held = 1; m_last = w;
          if (m_cnt[w] < CMAX) m_cnt[w]++;
        end
      end
      for (int i = 0; i < NREQ; i++) if (!req[i]) m_mask[i] = 1'b0;
      if (pre) m_mask[pre_idx] = 1'b1;
      if (cfg_cnt_clr) begin
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        m_sticky = pre;
      end else if (pre) m_sticky = 1'b1;
    end
    #1;
  endtask

  task automatic settle();
    req = '0;
    cfg_cnt_clr = 1'b1;
    tick();
    cfg_cnt_clr = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    ARESET = 1'b1; cfg_enable = 1'b0; cfg_mode = 1'b0; cfg_max_hold = '0;
    cfg_cnt_clr = 1'b0; req = '0;
    tick(); tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
    total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL reset_gnt_valid got=%b want=0", gnt_valid); end
    total++; if (timeout_sticky !== 1'b0) begin bad++; $display("FAIL reset_sticky got=%b want=0", timeout_sticky); end
    total++; if (gnt_cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%h want=0", gnt_cnt); end
    ARESET = 1'b0;
    tick();
  endtask

  task automatic test_rr_fairness();
    logic [NREQ-1:0] seq[$];
    logic [NREQ-1:0] prev;
    logic [NREQ-1:0] want;
    prev = '0;
    cfg_enable = 1'b1; cfg_mode = 1'b0; cfg_max_hold = '0;
    for (int c = 0; c < 40; c++) begin
      req = 4'b1111;
      if (m_cur >= 0 && m_held == 3) req[m_cur] = 1'b0;
      tick();
      total++; if (gnt !== exp_gnt()) begin bad++; $display("FAIL rr_gnt c=%0d got=%b want=%b", c, gnt, exp_gnt()); end
      if (gnt != 0 && prev == 0) seq.push_back(gnt);
      prev = gnt;
    end
    total++; if (seq.size() < 5) begin bad++; $display("FAIL rr_grant_count got=%0d want>=5", seq.size()); end
    for (int k = 0; k < 5 && k < seq.size(); k++) begin
      want = NREQ'(1 << (k % NREQ));
      total++; if (seq[k] !== want) begin bad++; $display("FAIL rr_order k=%0d got=%b want=%b", k, seq[k], want); end
    end
  endtask

  task automatic test_fixed_priority();
    int ng1;
    int n3;
    logic [NREQ-1:0] prev;
    settle();
    ng1 = 0; n3 = 0; prev = '0;
    cfg_mode = 1'b1;
    for (int c = 0; c < 30; c++) begin
      req = (m_cur == 1 && m_held == 2) ? 4'b1000 : 4'b1010;
      tick();
      total++; if (gnt !== exp_gnt()) begin bad++; $display("FAIL fixed_gnt c=%0d got=%b want=%b", c, gnt, exp_gnt()); end
      if (gnt == 4'b0010 && prev == 0) ng1++;
      if (gnt == 4'b1000) n3++;
      prev = gnt;
    end
    total++; if (n3 != 0) begin bad++; $display("FAIL fixed_req3_granted got=%0d want=0", n3); end
    total++; if (cnt_of(1) !== CW'(ng1)) begin bad++; $display("FAIL fixed_cnt1 got=%0d want=%0d", cnt_of(1), ng1); end
    total++; if (cnt_of(3) !== '0) begin bad++; $display("FAIL fixed_cnt3 got=%0d want=0", cnt_of(3)); end
    cfg_mode = 1'b0;
  endtask

  task automatic test_preempt();
    int n0;
    int n2;
    settle();
    n0 = 0; n2 = 0;
    cfg_max_hold = 8'd4; req = 4'b0101;
    for (int c = 0; c < 20; c++) begin
      tick();
      total++; if (gnt !== exp_gnt()) begin bad++; $display("FAIL preempt_gnt c=%0d got=%b want=%b", c, gnt, exp_gnt()); end
      if (gnt == 4'b0001) n0++;
      if (gnt == 4'b0100) n2++;
    end
    total++; if (n0 != 4) begin bad++; $display("FAIL preempt_len0 got=%0d want=4", n0); end
    total++; if (n2 != 4) begin bad++; $display("FAIL preempt_len2 got=%0d want=4", n2); end
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL preempt_masked got=%b want=0000", gnt); end
    total++; if (timeout_sticky !== 1'b1) begin bad++; $display("FAIL preempt_sticky got=%b want=1", timeout_sticky); end
    req = 4'b0100; tick();
    req = 4'b0101;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++; if (gnt !== exp_gnt()) begin bad++; $display("FAIL preempt_regrant c=%0d got=%b want=%b", c, gnt, exp_gnt()); end
    end
    cfg_max_hold = '0;
  endtask

  task automatic test_enable_gating();
    int n;
    settle();
    n = 0;
    cfg_enable = 1'b0; req = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      tick();
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL en_off_gnt c=%0d got=%b want=0000", c, gnt); end
    end
    cfg_enable = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (m_cur == 0 && m_held == 2) cfg_enable = 1'b0;
      if (c == 12) req = 4'b0000;
      if (c == 20) req = 4'b0001;
      tick();
      total++; if (gnt !== exp_gnt()) begin bad++; $display("FAIL en_gnt c=%0d got=%b want=%b", c, gnt, exp_gnt()); end
      if (gnt == 4'b0001) n++;
    end
    total++; if (n != 12) begin bad++; $display("FAIL en_grant_len got=%0d want=12", n); end
    cfg_enable = 1'b1;
  endtask

  task automatic test_hold_saturation();
    settle();
    cfg_max_hold = '0; req = 4'b0001;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (gnt !== exp_gnt()) begin total++; bad++; $display("FAIL hsat_gnt c=%0d got=%b want=%b", c, gnt, exp_gnt()); end
      else total++;
    end
    cfg_max_hold = 8'd255;
    for (int c = 0; c < 5; c++) tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL hsat_release got=%b want=0000", gnt); end
    total++; if (timeout_sticky !== 1'b1) begin bad++; $display("FAIL hsat_sticky got=%b want=1", timeout_sticky); end
    cfg_max_hold = '0;
  endtask

  task automatic test_counters();
    settle();
    for (int g = 0; g < 3; g++) begin
      req = 4'b0100; tick();
      req = 4'b0000; tick();
    end
    total++; if (cnt_of(2) !== 4'd3) begin bad++; $display("FAIL cnt_three got=%0d want=3", cnt_of(2)); end
    cfg_cnt_clr = 1'b1; tick(); cfg_cnt_clr = 1'b0;
    total++; if (cnt_of(2) !== 4'd0) begin bad++; $display("FAIL cnt_clear got=%0d want=0", cnt_of(2)); end
    req = 4'b0100; cfg_cnt_clr = 1'b1; tick(); cfg_cnt_clr = 1'b0;
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL cnt_clr_grant got=%b want=0100", gnt); end
    total++; if (cnt_of(2) !== 4'd0) begin bad++; $display("FAIL cnt_clr_wins got=%0d want=0", cnt_of(2)); end
    req = 4'b0000; tick();
    for (int g = 0; g < 20; g++) begin
      req = 4'b0100; tick();
      req = 4'b0000; tick();
    end
    total++; if (cnt_of(2) !== 4'd15) begin bad++; $display("FAIL cnt_saturate got=%0d want=15", cnt_of(2)); end
    cfg_max_hold = 8'd2; req = 4'b0001;
    tick(); tick();
    cfg_cnt_clr = 1'b1; tick();
    total++; if (timeout_sticky !== 1'b1) begin bad++; $display("FAIL sticky_set_wins got=%b want=1", timeout_sticky); end
    tick(); cfg_cnt_clr = 1'b0;
    total++; if (timeout_sticky !== 1'b0) begin bad++; $display("FAIL sticky_clear got=%b want=0", timeout_sticky); end
    cfg_max_hold = '0;
  endtask

  task automatic test_reset_mid_grant();
    settle();
    req = 4'b0100; tick(); tick();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL rst_pre_gnt got=%b want=0100", gnt); end
    ARESET = 1'b1; tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rst_mid_gnt got=%b want=0000", gnt); end
    total++; if (gnt_cnt !== '0) begin bad++; $display("FAIL rst_mid_cnt got=%h want=0", gnt_cnt); end
    ARESET = 1'b0; req = 4'b1111; tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rst_first_rr got=%b want=0001", gnt); end
  endtask

  task automatic test_random();
    int holds[5] = '{0, 1, 2, 3, 6};
    settle();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
      cfg_enable  = ($urandom_range(0, 9) != 0);
      cfg_cnt_clr = ($urandom_range(0, 29) == 0);
      ARESET      = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) cfg_mode = ~cfg_mode;
      if ($urandom_range(0, 99) == 0) cfg_max_hold = HW'(holds[$urandom_range(0, 4)]);
      tick();
      total++; if (gnt !== exp_gnt()) begin bad++; $display("FAIL rnd_gnt c=%0d got=%b want=%b", c, gnt, exp_gnt()); end
      total++; if (gnt_valid !== (m_cur >= 0)) begin bad++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, gnt_valid, m_cur >= 0); end
      total++; if (timeout_sticky !== m_sticky) begin bad++; $display("FAIL rnd_sticky c=%0d got=%b want=%b", c, timeout_sticky, m_sticky); end
      for (int i = 0; i < NREQ; i++) begin
        total++; if (cnt_of(i) !== CW'(m_cnt[i])) begin bad++; $display("FAIL rnd_cnt%0d c=%0d got=%0d want=%0d", i, c, cnt_of(i), m_cnt[i]); end
      end
    end
    ARESET = 1'b0; cfg_cnt_clr = 1'b0;
  endtask

  initial begin
    m_cur = -1; m_held = 0; m_last = NREQ - 1; m_sticky = 1'b0;
    for (int i = 0; i < NREQ; i++) begin m_mask[i] = 1'b0; m_cnt[i] = 0; end
    test_reset();
    test_rr_fairness();
    test_fixed_priority();
    test_preempt();
    test_enable_gating();
    test_hold_saturation();
    test_counters();
    test_reset_mid_grant();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
